vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA timing generator: consumes its column/row/display/sync outputs.
- Reads each visible pixel from an external single-port synchronous video RAM and drives registered RGB (3-3-2) plus sync signals delayed to match.
- Arbitrates host writes into the same RAM with a req/ack handshake; writes are granted only during blanking.

Parameters:
- XWidth, 8, column width; must match the timing generator.
- YWidth, 8, row width; must match the timing generator.
- DataWidth, 8, pixel word width, RGB 3-3-2 packed {R[7:5],G[4:2],B[1:0]}.
- AddrWidth, XWidth+YWidth, RAM address width; address = {row,col}.

Ports:
- Clock  in  1  system/pixel clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iCol  in  XWidth  current column from timing generator.
- iRow  in  YWidth  current row from timing generator.
- iDisplay  in  1  visible-area flag.
- iHSync  in  1  horizontal sync, active low.
- iVSync  in  1  vertical sync, active low.
- iWrReq  in  1  host write request; held high until oWrAck.
- iWrAddr  in  AddrWidth  host write address; stable while iWrReq is high.
- iWrData  in  DataWidth  host write data; stable while iWrReq is high.
- oWrAck  out  1  one-cycle pulse: the write was committed to RAM.
- oMemAddr  out  AddrWidth  RAM address, registered.
- oMemWe  out  1  RAM write enable, registered.
- oMemWData  out  DataWidth  RAM write data, registered.
- iMemRData  in  DataWidth  RAM read data, valid 1 cycle after oMemAddr.
- oRed  out  3  pixel red.
- oGreen  out  3  pixel green.
- oBlue  out  2  pixel blue.
- oHSync  out  1  delayed HSync.
- oVSync  out  1  delayed VSync.
- oDisplay  out  1  delayed display flag.

Behaviour:
- Reset (Reset=0, asynchronous):
  - oMemAddr=0, oMemWe=0, oMemWData=0, oWrAck=0, oRed/oGreen/oBlue=0.
  - oHSync=1, oVSync=1, oDisplay=0.
  - All pipeline stages cleared to the same values; FSM goes to IDLE.
- Pipeline, inputs sampled at edge N:
  - S1 (N+1): oMemAddr={iRow,iCol} when iDisplay=1; display/sync bits registered.
  - S2 (N+2): iMemRData valid; display/sync shifted.
  - S3 (N+3): RGB registered from iMemRData if S2 display=1, else RGB=0; oHSync/oVSync/oDisplay updated.
  - Total latency 3 cycles. Syncs and display are delayed by exactly 3 cycles so they stay aligned with RGB.
- FSM states: IDLE, FETCH, WRITE, ACK.
  - IDLE: oMemWe=0. iDisplay=1 -> FETCH. iDisplay=0 and iWrReq=1 -> WRITE. Otherwise stay.
  - FETCH: a read issues every cycle (oMemWe=0). Leave on iDisplay=0: to WRITE if iWrReq=1, else IDLE.
  - WRITE (one cycle): oMemAddr=iWrAddr, oMemWData=iWrData, oMemWe=1 on the S1 register edge -> ACK.
  - ACK (one cycle): oWrAck=1, oMemWe=0. Host must drop or re-present iWrReq the next cycle. Then iDisplay=1 -> FETCH; iDisplay=0 and iWrReq=1 -> WRITE; else IDLE.
- Write throughput: at most 1 write every 2 cycles during blanking.
- Display always wins: if iDisplay rises in the same cycle as a pending iWrReq, the read is issued and the request waits. No write is ever issued while iDisplay=1.
- A write accepted in the cycle iDisplay falls does not corrupt the in-flight read. The sync RAM returns the read data of the previous address on the write cycle.
- iWrReq held across an entire visible line stalls without loss; it is granted at the first blanking cycle.
- Reset mid-write: oMemWe deasserts immediately (asynchronous); no oWrAck is issued. The host must re-request.
- Address wrap: {row,col} concatenation, no arithmetic; a full frame maps to 2^AddrWidth words.

Decomposition:
- Shared package holds FSM state encodings (IDLE=0, FETCH=1, WRITE=2, ACK=3) as constants.
- Shared package also holds the RGB field slice constants and the pipeline depth constant PIPE_DEPTH=3.
- One natural sub-module: vga_sync_delay, a parameterised N-stage shift register for {HSync,VSync,Display}, reset to {1,1,0}.

Test Plan:
- Reset: hold Reset=0 with random inputs -> oHSync=1, oVSync=1, oDisplay=0, RGB=0, oMemWe=0, oWrAck=0.
- Read latency: iDisplay=1, iRow=8'h02, iCol=8'h05; RAM model returns 8'hE3.
  - oMemAddr=16'h0205 at N+1.
  - oRed=3'b111, oGreen=3'b000, oBlue=2'b11 at N+3, with oDisplay=1 in the same cycle.
- Blanking write: iDisplay=0, iWrReq=1, iWrAddr=16'h1234, iWrData=8'hAA.
  - oMemWe=1 with oMemAddr=16'h1234 and oMemWData=8'hAA for one cycle.
  - oWrAck pulse the next cycle.
  - A later read of 0x1234 yields 8'hAA.
- Collision: iWrReq asserted during a 256-pixel visible line -> oMemWe stays 0 for the whole line; the write is granted 1 cycle after iDisplay falls.
- Sync alignment: drive an HSync low pulse of 96 cycles -> oHSync low for exactly 96 cycles, delayed 3 cycles; RGB=0 whenever oDisplay=0.
- Back-to-back writes: 4 requests during a 16-cycle blanking window -> 4 acks, spaced 2 cycles apart, all data committed.

Source files
------------

// File: rtl/vga_pixel_fetch_pkg.sv
// ---------------------------------------------------------------------------
// vga_pixel_fetch_pkg
// Shared definitions for the VGA pixel fetch slice: fetch/write arbiter
// state encodings, RGB 3-3-2 field positions inside a pixel word, the
// read pipeline depth and the idle value of the {HSync,VSync,Display}
// delay line.
// ---------------------------------------------------------------------------
package vga_pixel_fetch_pkg;

   // Cycles from timing-generator inputs to registered RGB/sync outputs.
   localparam int PIPE_DEPTH = 3;

   // Pixel word layout {R[7:5], G[4:2], B[1:0]}.
   localparam int RED_MSB   = 7;
   localparam int RED_LSB   = 5;
   localparam int GREEN_MSB = 4;
   localparam int GREEN_LSB = 2;
   localparam int BLUE_MSB  = 1;
   localparam int BLUE_LSB  = 0;

   // {HSync, VSync, Display}: syncs are active low, so idle is {1,1,0}.
   localparam logic [2:0] SYNC_IDLE = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      ACK   = 2'd3
   } fetchState_t;

endpackage

// File: rtl/vga_pixel_fetch_sync_delay.sv
// ---------------------------------------------------------------------------
// vga_sync_delay
// N-stage shift register carrying {HSync, VSync, Display} alongside the
// pixel read pipeline so the syncs stay aligned with RGB.
//
// Ports:
//   Clock        in   pixel clock, rising edge
//   Reset        in   asynchronous active-low reset, stages go to {1,1,0}
//   iHSync       in   horizontal sync (active low)
//   iVSync       in   vertical sync (active low)
//   iDisplay     in   visible-area flag
//   oHSync       out  iHSync delayed Depth cycles
//   oVSync       out  iVSync delayed Depth cycles
//   oDisplay     out  iDisplay delayed Depth cycles
//   oTapDisplay  out  iDisplay delayed Depth-1 cycles (qualifies RAM data)
// ---------------------------------------------------------------------------
module vga_sync_delay
   import vga_pixel_fetch_pkg::*;
#(
   parameter int Depth = PIPE_DEPTH   // must be >= 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iHSync,
   input  logic iVSync,
   input  logic iDisplay,
   output logic oHSync,
   output logic oVSync,
   output logic oDisplay,
   output logic oTapDisplay
);

   // Stage k lives in bits [3k+2:3k] as {HSync, VSync, Display}; stage 0
   // is the newest sample.
   logic [3*Depth-1:0] shiftReg;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         shiftReg <= {Depth{SYNC_IDLE}};
      end else begin
         shiftReg <= {shiftReg[3*(Depth-1)-1:0], iHSync, iVSync, iDisplay};
      end
   end

   assign oHSync      = shiftReg[3*(Depth-1)+2];
   assign oVSync      = shiftReg[3*(Depth-1)+1];
   assign oDisplay    = shiftReg[3*(Depth-1)];
   assign oTapDisplay = shiftReg[3*(Depth-2)];

endmodule

// File: rtl/vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// vga_pixel_fetch
// Sits behind the VGA timing generator. Every visible pixel is read from an
// external single-port synchronous video RAM at address {row,col}; the data
// comes back one cycle after the address and is registered as RGB 3-3-2.
// Host writes share the RAM port and are only granted during blanking.
//
// Ports:
//   Clock      in   pixel clock, rising edge
//   Reset      in   asynchronous active-low reset
//   iCol/iRow  in   current column/row from the timing generator
//   iDisplay   in   visible-area flag
//   iHSync     in   horizontal sync, active low
//   iVSync     in   vertical sync, active low
//   iWrReq     in   host write request, held until oWrAck
//   iWrAddr    in   host write address (stable while iWrReq)
//   iWrData    in   host write data (stable while iWrReq)
//   oWrAck     out  one-cycle pulse after the write cycle
//   oMemAddr   out  RAM address (registered)
//   oMemWe     out  RAM write enable (registered)
//   oMemWData  out  RAM write data (registered)
//   iMemRData  in   RAM read data, valid one cycle after oMemAddr
//   oRed/oGreen/oBlue  out  registered pixel colour, zero outside display
//   oHSync/oVSync/oDisplay  out  inputs delayed to line up with RGB
// ---------------------------------------------------------------------------
module vga_pixel_fetch
   import vga_pixel_fetch_pkg::*;
#(
   parameter int XWidth    = 8,
   parameter int YWidth    = 8,
   parameter int DataWidth = 8,
   parameter int AddrWidth = XWidth + YWidth
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [XWidth-1:0]    iCol,
   input  logic [YWidth-1:0]    iRow,
   input  logic                 iDisplay,
   input  logic                 iHSync,
   input  logic                 iVSync,
   input  logic                 iWrReq,
   input  logic [AddrWidth-1:0] iWrAddr,
   input  logic [DataWidth-1:0] iWrData,
   output logic                 oWrAck,
   output logic [AddrWidth-1:0] oMemAddr,
   output logic                 oMemWe,
   output logic [DataWidth-1:0] oMemWData,
   input  logic [DataWidth-1:0] iMemRData,
   output logic [2:0]           oRed,
   output logic [2:0]           oGreen,
   output logic [1:0]           oBlue,
   output logic                 oHSync,
   output logic                 oVSync,
   output logic                 oDisplay
);

   fetchState_t          state;
   logic                 tapDisplay;
   logic [DataWidth-1:0] rgbReg;

   // Arbiter and RAM port registers (pipeline stage S1). Display always
   // wins: a write is only launched from a cycle where iDisplay is low, and
   // a pixel arriving during WRITE still gets its read address issued so no
   // visible pixel is ever skipped.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         oMemAddr  <= '0;
         oMemWe    <= 1'b0;
         oMemWData <= '0;
         oWrAck    <= 1'b0;
      end else begin
         oMemWe <= 1'b0;
         oWrAck <= 1'b0;
         case (state)
            WRITE: begin
               // The RAM commits on the edge ending this cycle; acknowledge next.
               state  <= ACK;
               oWrAck <= 1'b1;
               if (iDisplay) begin
                  oMemAddr <= {iRow, iCol};
               end
            end
            IDLE, FETCH, ACK: begin
               if (iDisplay) begin
                  state    <= FETCH;
                  oMemAddr <= {iRow, iCol};
               end else if (iWrReq) begin
                  state     <= WRITE;
                  oMemWe    <= 1'b1;
                  oMemAddr  <= iWrAddr;
                  oMemWData <= iWrData;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // S3: capture RAM data only for pixels that were actually fetched. During
   // a write cycle the RAM returns stale data, but its delayed display bit is
   // always low there, so it is masked to black.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rgbReg <= '0;
      end else if (tapDisplay) begin
         rgbReg <= iMemRData;
      end else begin
         rgbReg <= '0;
      end
   end

   assign oRed   = rgbReg[RED_MSB:RED_LSB];
   assign oGreen = rgbReg[GREEN_MSB:GREEN_LSB];
   assign oBlue  = rgbReg[BLUE_MSB:BLUE_LSB];

   vga_sync_delay #(
      .Depth(PIPE_DEPTH)
   ) uSyncDelay (
      .Clock      (Clock),
      .Reset      (Reset),
      .iHSync     (iHSync),
      .iVSync     (iVSync),
      .iDisplay   (iDisplay),
      .oHSync     (oHSync),
      .oVSync     (oVSync),
      .oDisplay   (oDisplay),
      .oTapDisplay(tapDisplay)
   );

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_fetch
// Scoreboard bench for vga_pixel_fetch with a behavioural synchronous RAM
// (read-old-data on a write cycle). Stimulus pushes expected pixels, writes,
// acks and sync pulses; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_vga_pixel_fetch;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [7:0]  iCol, iRow;
   logic        iDisplay, iHSync, iVSync, iWrReq;
   logic [15:0] iWrAddr;
   logic [7:0]  iWrData;
   logic        oWrAck;
   logic [15:0] oMemAddr;
   logic        oMemWe;
   logic [7:0]  oMemWData;
   logic [7:0]  iMemRData;
   logic [2:0]  oRed, oGreen;
   logic [1:0]  oBlue;
   logic        oHSync, oVSync, oDisplay;

   vga_pixel_fetch dut (
      .Clock(Clock), .Reset(Reset), .iCol(iCol), .iRow(iRow),
      .iDisplay(iDisplay), .iHSync(iHSync), .iVSync(iVSync),
      .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData),
      .oWrAck(oWrAck), .oMemAddr(oMemAddr), .oMemWe(oMemWe),
      .oMemWData(oMemWData), .iMemRData(iMemRData),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
      .oHSync(oHSync), .oVSync(oVSync), .oDisplay(oDisplay)
   );

   always #5 Clock = ~Clock;

   int cycle = 0;
   always @(posedge Clock) cycle <= cycle + 1;

   // Video RAM model
   logic [7:0] mem [0:65535];
   always @(posedge Clock) begin
      if (oMemWe) mem[oMemAddr] <= oMemWData;
      iMemRData <= mem[oMemAddr];
   end

   typedef struct { logic [7:0] d; int due; } pix_t;
   typedef struct { logic [15:0] a; logic [7:0] d; int due; } wr_t;
   typedef struct { int start; int len; } pulse_t;

   pix_t   pixQ[$];
   wr_t    wrQ[$];
   int     ackQ[$];
   pulse_t hQ[$];
   pulse_t vQ[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]};
   endfunction

   // ---------------- monitor ----------------
   pix_t   mp;
   wr_t    mw;
   pulse_t mpl;
   int     ma;
   bit     prevH = 1'b1, prevV = 1'b1;
   int     hStart = 0, vStart = 0;

   always @(negedge Clock) begin
      if (!Reset) begin
         prevH = 1'b1;
         prevV = 1'b1;
      end else begin
         if (oDisplay) begin
            if (pixQ.size() == 0) begin
               check(0, "pix_unexpected", {oRed, oGreen, oBlue}, 0);
            end else begin
               mp = pixQ.pop_front();
               check({oRed, oGreen, oBlue} == mp.d, "pix_rgb", {oRed, oGreen, oBlue}, mp.d);
               check(cycle == mp.due, "pix_latency", cycle, mp.due);
            end
         end else begin
            check({oRed, oGreen, oBlue} == 8'h00, "rgb_blank", {oRed, oGreen, oBlue}, 0);
         end
         if (oMemWe) begin
            if (wrQ.size() == 0) begin
               check(0, "we_unexpected", oMemAddr, 0);
            end else begin
               mw = wrQ.pop_front();
               $display("write addr=%h data=%h cycle=%0d", oMemAddr, oMemWData, cycle);
               check(oMemAddr == mw.a, "we_addr", oMemAddr, mw.a);
               check(oMemWData == mw.d, "we_data", oMemWData, mw.d);
               check(cycle == mw.due, "we_cycle", cycle, mw.due);
            end
         end
         if (oWrAck) begin
            if (ackQ.size() == 0) begin
               check(0, "ack_unexpected", cycle, 0);
            end else begin
               ma = ackQ.pop_front();
               $display("ack cycle=%0d", cycle);
               check(cycle == ma, "ack_cycle", cycle, ma);
            end
         end
         if (prevH && !oHSync) hStart = cycle;
         if (!prevH && oHSync) begin
            if (hQ.size() == 0) begin
               check(0, "hsync_unexpected", cycle, 0);
            end else begin
               mpl = hQ.pop_front();
               $display("hsync pulse start=%0d len=%0d", hStart, cycle - hStart);
               check(hStart == mpl.start, "hsync_start", hStart, mpl.start);
               check(cycle - hStart == mpl.len, "hsync_len", cycle - hStart, mpl.len);
            end
         end
         if (prevV && !oVSync) vStart = cycle;
         if (!prevV && oVSync) begin
            if (vQ.size() == 0) begin
               check(0, "vsync_unexpected", cycle, 0);
            end else begin
               mpl = vQ.pop_front();
               $display("vsync pulse start=%0d len=%0d", vStart, cycle - vStart);
               check(vStart == mpl.start, "vsync_start", vStart, mpl.start);
               check(cycle - vStart == mpl.len, "vsync_len", cycle - vStart, mpl.len);
            end
         end
         prevH = oHSync;
         prevV = oVSync;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic idle();
      iDisplay = 1'b0;
      iHSync   = 1'b1;
      iVSync   = 1'b1;
   endtask

   task automatic pixel(input logic [7:0] r, input logic [7:0] c, input logic [7:0] exp);
      iDisplay = 1'b1;
      iRow     = r;
      iCol     = c;
      pixQ.push_back('{exp, cycle + 3});
      tick(1);
      check(oMemAddr == {r, c}, "read_addr", oMemAddr, {r, c});
   endtask

   task automatic waitAck();
      bit got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         tick(1);
         if (oWrAck) got = 1'b1;
      end
      check(got, "ack_wait", got, 1);
   endtask

   task automatic hostWrite(input logic [15:0] a, input logic [7:0] d);
      iWrReq  = 1'b1;
      iWrAddr = a;
      iWrData = d;
      wrQ.push_back('{a, d, cycle + 1});
      ackQ.push_back(cycle + 2);
      waitAck();
      iWrReq = 1'b0;
   endtask

   int s;

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      mem[16'h0205] = 8'hE3;

      // Reset with random inputs
      Reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         iCol = 8'($urandom); iRow = 8'($urandom);
         iDisplay = 1'($urandom); iHSync = 1'($urandom); iVSync = 1'($urandom);
         iWrReq = 1'($urandom); iWrAddr = 16'($urandom); iWrData = 8'($urandom);
         tick(1);
         check(oHSync == 1'b1, "rst_hsync", oHSync, 1);
         check(oVSync == 1'b1, "rst_vsync", oVSync, 1);
         check(oDisplay == 1'b0, "rst_display", oDisplay, 0);
         check({oRed, oGreen, oBlue} == 8'h00, "rst_rgb", {oRed, oGreen, oBlue}, 0);
         check(oMemWe == 1'b0, "rst_we", oMemWe, 0);
         check(oWrAck == 1'b0, "rst_ack", oWrAck, 0);
         check(oMemAddr == 16'h0000, "rst_addr", oMemAddr, 0);
      end
      idle();
      iWrReq = 1'b0;
      tick(2);
      Reset = 1'b1;
      tick(4);

      // Read latency: 0x0205 -> E3 = R 111, G 000, B 11
      pixel(8'h02, 8'h05, 8'hE3);
      idle();
      tick(5);

      // Blanking write then read back
      hostWrite(16'h1234, 8'hAA);
      tick(3);
      pixel(8'h12, 8'h34, 8'hAA);
      idle();
      tick(5);

      // Collision: request held across a full 256-pixel line
      iWrReq  = 1'b1;
      iWrAddr = 16'h4321;
      iWrData = 8'h5A;
      for (int c = 0; c < 256; c++) pixel(8'h03, 8'(c), pat({8'h03, 8'(c)}));
      idle();
      wrQ.push_back('{16'h4321, 8'h5A, cycle + 1});
      ackQ.push_back(cycle + 2);
      waitAck();
      iWrReq = 1'b0;
      tick(3);
      pixel(8'h43, 8'h21, 8'h5A);
      pixel(8'h03, 8'hFF, pat(16'h03FF));
      idle();
      tick(5);

      // Sync alignment
      iHSync = 1'b0;
      hQ.push_back('{cycle + 3, 96});
      tick(96);
      iHSync = 1'b1;
      tick(4);
      iVSync = 1'b0;
      vQ.push_back('{cycle + 3, 5});
      tick(5);
      iVSync = 1'b1;
      tick(6);

      // Back-to-back writes in a 16-cycle blanking window
      s = cycle;
      hostWrite(16'h00A0, 8'h10);
      hostWrite(16'h00A1, 8'h21);
      hostWrite(16'h00A2, 8'h32);
      hostWrite(16'h00A3, 8'h43);
      check(cycle - s == 8, "b2b_span", cycle - s, 8);
      tick(3);
      pixel(8'h00, 8'hA0, 8'h10);
      pixel(8'h00, 8'hA1, 8'h21);
      pixel(8'h00, 8'hA2, 8'h32);
      pixel(8'h00, 8'hA3, 8'h43);
      idle();
      tick(5);

      // Reset in the middle of a write cycle
      iWrReq  = 1'b1;
      iWrAddr = 16'h7777;
      iWrData = 8'h11;
      tick(1);
      check(oMemWe == 1'b1, "midrst_we_up", oMemWe, 1);
      #2;
      Reset = 1'b0;
      #1;
      check(oMemWe == 1'b0, "midrst_we_drop", oMemWe, 0);
      iWrReq = 1'b0;
      tick(3);
      Reset = 1'b1;
      tick(4);
      pixel(8'h77, 8'h77, pat(16'h7777));
      idle();
      tick(10);

      check(pixQ.size() == 0, "pixq_drained", pixQ.size(), 0);
      check(wrQ.size() == 0, "wrq_drained", wrQ.size(), 0);
      check(ackQ.size() == 0, "ackq_drained", ackQ.size(), 0);
      check(hQ.size() + vQ.size() == 0, "syncq_drained", hQ.size() + vQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
